flight_ctrl_sequencer: RTL and testbench

Parametrised multi-channel control-loop sequencer for the flight controller. Each loop period it reads NUM_CH sensor words over the SPI master, converts each into a PWM duty value, and commits all duty values to the PWM bank together in one cycle. It then sends a telemetry frame through the UART transmitter. It sits between the SPI/UART peripherals and the PWM generators and replaces the single-channel control FSM.

---
 rtl/flight_ctrl_pkg.sv | 23 ++
 rtl/flight_ctrl_sequencer_loop_timer.sv | 30 +++
 rtl/flight_ctrl_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_flight_ctrl_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flight_ctrl_pkg.sv
// Shared definitions for the flight-control loop sequencer: FSM state
// encoding, telemetry frame header and channel-index width helper.
package flight_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WAIT_SPI = 3'd2,
        ST_LATCH    = 3'd3,
        ST_COMMIT   = 3'd4,
        ST_TX       = 3'd5,
        ST_WAIT_TX  = 3'd6,
        ST_HOLD     = 3'd7
    } fcs_state_e;

    localparam logic [7:0] TLM_HEADER = 8'hA5;

    // Channel index needs at least one bit even for a single channel.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flight_ctrl_sequencer_loop_timer.sv
// loop_timer: free-running PERIOD_CYC down-counter. restart reloads it; tick
// is high for the single cycle in which the count sits at zero.
module loop_timer #(
    parameter int PERIOD_CYC = 100000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A restart in cycle t puts the count at zero exactly PERIOD_CYC cycles later.
    always_comb begin
        cnt_d = cnt_q - CNT_W'(1);
        if (restart || (cnt_q == '0)) cnt_d = RELOAD;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= RELOAD;
        else          cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/flight_ctrl_sequencer.sv
// Multi-channel control-loop sequencer: SPI sensor reads, atomic PWM duty
// commit, UART telemetry frame. Optional handshake watchdog: FCS_WATCHDOG_EN.
module flight_ctrl_sequencer
    import flight_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 16,
    parameter int DUTY_W      = 8,
    parameter int PERIOD_CYC  = 100000,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       spi_done,
    input  logic [DATA_W-1:0]          sensor_data,
    input  logic                       uart_done,
    output logic                       spi_start,
    output logic [ch_w(NUM_CH)-1:0]    spi_ch,
    output logic                       uart_start,
    output logic [DUTY_W-1:0]          uart_data,
    output logic [NUM_CH*DUTY_W-1:0]   duty_cycle,
    output logic                       busy,
    output logic                       fault,
    output logic [15:0]                frame_cnt
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int IDX_W = $clog2(NUM_CH + 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH);

    fcs_state_e                      state_q, state_d;
    logic [CH_W-1:0]                 ch_q, ch_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NUM_CH-1:0][DUTY_W-1:0]   stage_q, stage_d;
    logic [NUM_CH-1:0][DUTY_W-1:0]   duty_q, duty_d;
    logic [15:0]                     frame_cnt_q, frame_cnt_d;
    logic                            spi_start_q, spi_start_d;
    logic                            uart_start_q, uart_start_d;
    logic [DUTY_W-1:0]               uart_data_q, uart_data_d;
    logic                            busy_q, busy_d;
    logic                            pend_q, pend_d;
    logic                            restart, tick;
    logic                            wd_expire;
    logic                            fault_s;
    logic                            unused_sensor;

    assign unused_sensor = ^sensor_data;

    loop_timer #(.PERIOD_CYC(PERIOD_CYC)) u_loop_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .tick    (tick)
    );

`ifdef FCS_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            fault_q, fault_d;
    logic            in_wait, wait_done;

    assign in_wait   = (state_q == ST_WAIT_SPI) || (state_q == ST_WAIT_TX);
    assign wait_done = (state_q == ST_WAIT_SPI) ? spi_done : uart_done;

    // Counter is zero on the first cycle of a wait; a done in the expiry cycle wins.
    always_comb begin
        wd_cnt_d  = in_wait ? wd_cnt_q + WD_W'(1) : '0;
        wd_expire = in_wait && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) && !wait_done;
        fault_d   = fault_q | wd_expire;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            fault_q  <= fault_d;
        end
    end

    assign fault_s = fault_q;
`else
    localparam int unused_timeout = TIMEOUT_CYC;
    assign wd_expire = 1'b0;
    assign fault_s   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        idx_d       = idx_q;
        stage_d     = stage_q;
        duty_d      = duty_q;
        frame_cnt_d = frame_cnt_q;
        restart     = 1'b0;
        case (state_q)
            ST_IDLE: if (start && !fault_s) begin
                state_d = ST_READ;
                ch_d    = '0;
                restart = 1'b1;
            end
            ST_READ: state_d = ST_WAIT_SPI;
            // sensor_data is only guaranteed valid alongside spi_done, so capture it here.
            ST_WAIT_SPI: if (spi_done) begin
                state_d       = ST_LATCH;
                stage_d[ch_q] = sensor_data[DATA_W-1 -: DUTY_W];
            end
            ST_LATCH: if (ch_q == LAST_CH) begin
                state_d = ST_COMMIT;
            end else begin
                ch_d    = ch_q + CH_W'(1);
                state_d = ST_READ;
            end
            ST_COMMIT: begin
                duty_d  = stage_q;
                idx_d   = '0;
                state_d = ST_TX;
            end
            ST_TX: state_d = ST_WAIT_TX;
            ST_WAIT_TX: if (uart_done) begin
                if (idx_q == LAST_IDX) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_HOLD;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_TX;
                end
            end
            ST_HOLD: if (tick || pend_q) begin
                if (start && !fault_s) begin
                    state_d = ST_READ;
                    ch_d    = '0;
                    restart = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wd_expire) begin
            state_d = ST_IDLE;
            duty_d  = '0;
        end

        // A tick seen while the frame is still running lets HOLD exit at once.
        pend_d = restart ? 1'b0 : (pend_q | tick);

        spi_start_d  = (state_d == ST_READ);
        uart_start_d = (state_d == ST_TX);
        busy_d       = !((state_d == ST_IDLE) || (state_d == ST_HOLD));
        uart_data_d  = uart_data_q;
        if (state_d == ST_TX) begin
            uart_data_d = DUTY_W'(TLM_HEADER);
            for (int i = 0; i < NUM_CH; i++)
                if (idx_d == IDX_W'(i + 1)) uart_data_d = duty_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            idx_q        <= '0;
            stage_q      <= '0;
            duty_q       <= '0;
            frame_cnt_q  <= '0;
            spi_start_q  <= 1'b0;
            uart_start_q <= 1'b0;
            uart_data_q  <= '0;
            busy_q       <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            idx_q        <= idx_d;
            stage_q      <= stage_d;
            duty_q       <= duty_d;
            frame_cnt_q  <= frame_cnt_d;
            spi_start_q  <= spi_start_d;
            uart_start_q <= uart_start_d;
            uart_data_q  <= uart_data_d;
            busy_q       <= busy_d;
            pend_q       <= pend_d;
        end
    end

    assign spi_start  = spi_start_q;
    assign spi_ch     = ch_q;
    assign uart_start = uart_start_q;
    assign uart_data  = uart_data_q;
    assign duty_cycle = duty_q;
    assign busy       = busy_q;
    assign fault      = fault_s;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_flight_ctrl_sequencer.sv
// Directed bench for flight_ctrl_sequencer: u_dut (PERIOD 200) and u_ovr
// (PERIOD 20, overrun case), each with SPI/UART responders answering 5 cycles late.
module tb_flight_ctrl_sequencer;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start [2];
    logic        spi_done [2];
    logic [15:0] sensor_data [2];
    logic        uart_done [2];
    logic        spi_start [2];
    logic [1:0]  spi_ch [2];
    logic        uart_start [2];
    logic [7:0]  uart_data [2];
    logic [23:0] duty [2];
    logic        busy [2];
    logic        fault [2];
    logic [15:0] frame_cnt [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit withhold = 1'b0;
    logic [15:0] sens [3];
    int spi_cnt [2];
    int uart_cnt [2];

    int          ch0q[$];
    int          t0q[$];
    logic [7:0]  ub0q[$];
    logic [23:0] duty0q[$];
    int          ch1q[$];
    int          st1q[$];
    int          fc1q[$];
    logic [23:0] prev_duty0 = '0;
    logic [15:0] prev_fc1 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    flight_ctrl_sequencer #(.NUM_CH(3), .DATA_W(16), .DUTY_W(8), .PERIOD_CYC(200), .TIMEOUT_CYC(50)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .spi_done(spi_done[0]),
        .sensor_data(sensor_data[0]), .uart_done(uart_done[0]), .spi_start(spi_start[0]),
        .spi_ch(spi_ch[0]), .uart_start(uart_start[0]), .uart_data(uart_data[0]),
        .duty_cycle(duty[0]), .busy(busy[0]), .fault(fault[0]), .frame_cnt(frame_cnt[0])
    );

    flight_ctrl_sequencer #(.NUM_CH(3), .DATA_W(16), .DUTY_W(8), .PERIOD_CYC(20), .TIMEOUT_CYC(50)) u_ovr (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .spi_done(spi_done[1]),
        .sensor_data(sensor_data[1]), .uart_done(uart_done[1]), .spi_start(spi_start[1]),
        .spi_ch(spi_ch[1]), .uart_start(uart_start[1]), .uart_data(uart_data[1]),
        .duty_cycle(duty[1]), .busy(busy[1]), .fault(fault[1]), .frame_cnt(frame_cnt[1])
    );

    // Peripheral responders and event logs, all on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            spi_done[d]  = 1'b0;
            uart_done[d] = 1'b0;
            if (!reset_n) begin
                spi_cnt[d]     = 0;
                uart_cnt[d]    = 0;
                sensor_data[d] = '0;
            end else begin
                if (spi_cnt[d] > 0) begin
                    spi_cnt[d]--;
                    if (spi_cnt[d] == 0) begin
                        spi_done[d]    = 1'b1;
                        sensor_data[d] = sens[int'(spi_ch[d])];
                    end
                end
                if (uart_cnt[d] > 0) begin
                    uart_cnt[d]--;
                    if (uart_cnt[d] == 0) uart_done[d] = 1'b1;
                end
                if (spi_start[d] && !(d == 0 && withhold && spi_ch[d] == 2'd2)) spi_cnt[d] = LAT;
                if (uart_start[d]) uart_cnt[d] = LAT;
            end
        end
        if (reset_n) begin
            if (spi_start[0]) begin
                ch0q.push_back(int'(spi_ch[0]));
                if (spi_ch[0] == 2'd0) t0q.push_back(cyc);
            end
            if (uart_start[0]) ub0q.push_back(uart_data[0]);
            if (spi_start[1]) begin
                ch1q.push_back(int'(spi_ch[1]));
                st1q.push_back(cyc);
            end
        end
        if (duty[0] !== prev_duty0) begin
            duty0q.push_back(duty[0]);
            prev_duty0 = duty[0];
        end
        if (frame_cnt[1] !== prev_fc1) begin
            fc1q.push_back(cyc);
            prev_fc1 = frame_cnt[1];
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (spi_start[0] !== 1'b0) begin failures++; $display("FAIL rst_spi_start got=%0h exp=0", spi_start[0]); end
        checks++; if (spi_ch[0] !== 2'd0) begin failures++; $display("FAIL rst_spi_ch got=%0h exp=0", spi_ch[0]); end
        checks++; if (uart_start[0] !== 1'b0) begin failures++; $display("FAIL rst_uart_start got=%0h exp=0", uart_start[0]); end
        checks++; if (uart_data[0] !== 8'h00) begin failures++; $display("FAIL rst_uart_data got=%0h exp=0", uart_data[0]); end
        checks++; if (duty[0] !== 24'h0) begin failures++; $display("FAIL rst_duty got=%0h exp=0", duty[0]); end
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", busy[0]); end
        checks++; if (fault[0] !== 1'b0) begin failures++; $display("FAIL rst_fault got=%0h exp=0", fault[0]); end
        checks++; if (frame_cnt[0] !== 16'd0) begin failures++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt[0]); end
    endtask

    task automatic test_first_frame();
        int n = 0;
        ch0q.delete(); ub0q.delete(); duty0q.delete(); t0q.delete();
        reset_n = 1'b1;
        start[0] = 1'b1;
        while (frame_cnt[0] !== 16'd1 && n < 400) begin @(negedge clk); n++; end
        checks++; if (n >= 400) begin failures++; $display("FAIL ff_timeout got=%0d cycles exp<400", n); end
        checks++; if (ch0q.size() != 3 || ch0q[0] != 0 || ch0q[1] != 1 || ch0q[2] != 2) begin
            failures++; $display("FAIL ff_spi_ch_seq got_size=%0d exp channels 0,1,2", ch0q.size()); end
        checks++; if (ub0q.size() != 4 || ub0q[0] !== 8'hA5 || ub0q[1] !== 8'h12 || ub0q[2] !== 8'hAB || ub0q[3] !== 8'hFF) begin
            failures++; $display("FAIL ff_uart_bytes got_size=%0d exp A5,12,AB,FF", ub0q.size()); end
        checks++; if (duty[0] !== 24'hFFAB12) begin failures++; $display("FAIL ff_duty got=%0h exp=ffab12", duty[0]); end
        checks++; if (duty0q.size() != 1 || duty0q[0] !== 24'hFFAB12) begin
            failures++; $display("FAIL ff_duty_single_update got_changes=%0d exp=1 to ffab12", duty0q.size()); end
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL ff_busy_hold got=%0h exp=0", busy[0]); end
    endtask

    task automatic test_period();
        int n = 0;
        while (t0q.size() < 3 && n < 700) begin @(negedge clk); n++; end
        checks++; if (t0q.size() < 3) begin failures++; $display("FAIL per_timeout got=%0d starts exp=3", t0q.size()); end
        else begin
            checks++; if (t0q[1] - t0q[0] != 200) begin failures++; $display("FAIL per_gap1 got=%0d exp=200", t0q[1] - t0q[0]); end
            checks++; if (t0q[2] - t0q[1] != 200) begin failures++; $display("FAIL per_gap2 got=%0d exp=200", t0q[2] - t0q[1]); end
        end
        checks++; if (frame_cnt[0] !== 16'd2) begin failures++; $display("FAIL per_frame_cnt got=%0d exp=2", frame_cnt[0]); end
    endtask

    task automatic test_start_drop();
        int n = 0;
        while (busy[0] !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        ch0q.delete(); ub0q.delete(); duty0q.delete();
        n = 0;
        while (!(spi_start[0] === 1'b1 && spi_ch[0] === 2'd1) && n < 300) begin @(negedge clk); n++; end
        checks++; if (n >= 300) begin failures++; $display("FAIL drop_wait_ch1 got=%0d cycles exp<300", n); end
        start[0] = 1'b0;
        repeat (300) @(negedge clk);
        checks++; if (ch0q.size() != 3 || ch0q[0] != 0 || ch0q[1] != 1 || ch0q[2] != 2) begin
            failures++; $display("FAIL drop_spi_seq got_size=%0d exp channels 0,1,2", ch0q.size()); end
        checks++; if (ub0q.size() != 4 || ub0q[0] !== 8'hA5 || ub0q[3] !== 8'hFF) begin
            failures++; $display("FAIL drop_uart_bytes got_size=%0d exp 4 bytes A5..FF", ub0q.size()); end
        checks++; if (frame_cnt[0] !== 16'd4) begin failures++; $display("FAIL drop_frame_cnt got=%0d exp=4", frame_cnt[0]); end
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL drop_busy got=%0h exp=0", busy[0]); end
        checks++; if (duty[0] !== 24'hFFAB12 || duty0q.size() != 0) begin
            failures++; $display("FAIL drop_duty_held got=%0h changes=%0d exp=ffab12 changes=0", duty[0], duty0q.size()); end
    endtask

    task automatic test_watchdog();
        int n = 0;
        ch0q.delete();
        withhold = 1'b1;
        start[0] = 1'b1;
        while (!(spi_start[0] === 1'b1 && spi_ch[0] === 2'd2) && n < 300) begin @(negedge clk); n++; end
        checks++; if (n >= 300) begin failures++; $display("FAIL wd_wait_ch2 got=%0d cycles exp<300", n); end
        repeat (50) @(negedge clk);
`ifdef FCS_WATCHDOG_EN
        checks++; if (fault[0] !== 1'b0 || busy[0] !== 1'b1) begin
            failures++; $display("FAIL wd_cycle50 got fault=%0h busy=%0h exp fault=0 busy=1", fault[0], busy[0]); end
        @(negedge clk);
        checks++; if (fault[0] !== 1'b1) begin failures++; $display("FAIL wd_fault got=%0h exp=1", fault[0]); end
        checks++; if (duty[0] !== 24'h0 || busy[0] !== 1'b0) begin
            failures++; $display("FAIL wd_safe got duty=%0h busy=%0h exp duty=0 busy=0", duty[0], busy[0]); end
        repeat (40) @(negedge clk);
        checks++; if (ch0q.size() != 3 || fault[0] !== 1'b1) begin
            failures++; $display("FAIL wd_start_ignored got_reads=%0d fault=%0h exp reads=3 fault=1", ch0q.size(), fault[0]); end
`else
        @(negedge clk);
        checks++; if (fault[0] !== 1'b0 || busy[0] !== 1'b1) begin
            failures++; $display("FAIL nowd_cycle51 got fault=%0h busy=%0h exp fault=0 busy=1", fault[0], busy[0]); end
        checks++; if (duty[0] !== 24'hFFAB12) begin failures++; $display("FAIL nowd_duty got=%0h exp=ffab12", duty[0]); end
        repeat (40) @(negedge clk);
        checks++; if (fault[0] !== 1'b0 || busy[0] !== 1'b1) begin
            failures++; $display("FAIL nowd_still_wait got fault=%0h busy=%0h exp fault=0 busy=1", fault[0], busy[0]); end
`endif
        withhold = 1'b0;
        start[0] = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (fault[0] !== 1'b0 || duty[0] !== 24'h0) begin
            failures++; $display("FAIL wd_reset_clear got fault=%0h duty=%0h exp 0 0", fault[0], duty[0]); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ch0q.delete(); ub0q.delete();
        reset_n = 1'b1;
        start[0] = 1'b1;
        while (uart_start[0] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++; if (busy[0] !== 1'b1 || uart_data[0] !== 8'hA5) begin
            failures++; $display("FAIL rm_in_wait_tx got busy=%0h data=%0h exp busy=1 data=a5", busy[0], uart_data[0]); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (spi_start[0] !== 1'b0 || uart_start[0] !== 1'b0 || busy[0] !== 1'b0 || spi_ch[0] !== 2'd0) begin
            failures++; $display("FAIL rm_ctrl_zero got spi=%0h uart=%0h busy=%0h ch=%0h exp all 0", spi_start[0], uart_start[0], busy[0], spi_ch[0]); end
        checks++; if (uart_data[0] !== 8'h0 || duty[0] !== 24'h0 || frame_cnt[0] !== 16'd0 || fault[0] !== 1'b0) begin
            failures++; $display("FAIL rm_data_zero got data=%0h duty=%0h cnt=%0d fault=%0h exp all 0", uart_data[0], duty[0], frame_cnt[0], fault[0]); end
        ch0q.delete(); ub0q.delete();
        reset_n = 1'b1;
        n = 0;
        while (frame_cnt[0] !== 16'd1 && n < 400) begin @(negedge clk); n++; end
        checks++; if (ch0q.size() != 3 || ch0q[0] != 0 || ch0q[1] != 1 || ch0q[2] != 2) begin
            failures++; $display("FAIL rm_restart_seq got_size=%0d exp channels 0,1,2", ch0q.size()); end
        checks++; if (ub0q.size() != 4 || ub0q[0] !== 8'hA5 || duty[0] !== 24'hFFAB12) begin
            failures++; $display("FAIL rm_restart_frame got_bytes=%0d duty=%0h exp 4 ffab12", ub0q.size(), duty[0]); end
    endtask

    task automatic test_overrun();
        int n = 0;
        bit seq_ok = 1'b1;
        ch1q.delete(); st1q.delete(); fc1q.delete();
        start[1] = 1'b1;
        while (frame_cnt[1] !== 16'd3 && n < 400) begin @(negedge clk); n++; end
        checks++; if (n >= 400) begin failures++; $display("FAIL ovr_timeout got=%0d cycles exp<400", n); end
        if (ch1q.size() < 9) seq_ok = 1'b0;
        else for (int i = 0; i < 9; i++) if (ch1q[i] != i % 3) seq_ok = 1'b0;
        checks++; if (!seq_ok) begin failures++; $display("FAIL ovr_channels got_size=%0d exp 0,1,2 x3", ch1q.size()); end
        if (st1q.size() >= 7 && fc1q.size() >= 2) begin
            checks++; if (st1q[3] - fc1q[0] != 1) begin failures++; $display("FAIL ovr_hold1 got=%0d exp=1", st1q[3] - fc1q[0]); end
            checks++; if (st1q[6] - fc1q[1] != 1) begin failures++; $display("FAIL ovr_hold2 got=%0d exp=1", st1q[6] - fc1q[1]); end
        end else begin
            checks++; failures++;
            $display("FAIL ovr_events got starts=%0d frames=%0d exp >=7 >=2", st1q.size(), fc1q.size());
        end
    endtask

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        sens[0] = 16'h1234;
        sens[1] = 16'hABCD;
        sens[2] = 16'hFF00;
        test_reset();
        test_first_frame();
        test_period();
        test_start_drop();
        test_watchdog();
        test_reset_mid();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
